plot_arbiter: RTL

Round-robin arbiter sharing the single VGA framebuffer write port (`vga_adapter` x/y/colour/plot) between several pixel-drawing engines: track redraw, car erase/redraw, HUD/timer overlay. Each engine requests the port, streams a burst of pixels once granted, and releases it with a last-pixel flag. The block sits between the drawing engines inside the game top level and the `vga_adapter` instance; its outputs drive the adapter directly.

---
 rtl/plot_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/plot_arbiter.sv
// Round-robin arbiter that shares the single vga_adapter write port between
// several pixel-drawing engines; each grant lasts one burst, ended by last/req drop/beat limit.
module plot_arbiter #(
    parameter int N_REQ     = 4,
    parameter int X_W       = 9,
    parameter int Y_W       = 8,
    parameter int C_W       = 6,
    parameter int MAX_BURST = 1024
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       pix_valid,
    input  logic [N_REQ-1:0]       pix_last,
    input  logic [N_REQ*X_W-1:0]   pix_x,
    input  logic [N_REQ*Y_W-1:0]   pix_y,
    input  logic [N_REQ*C_W-1:0]   pix_colour,
    output logic [N_REQ-1:0]       gnt,
    output logic [X_W-1:0]         xDisplay,
    output logic [Y_W-1:0]         yDisplay,
    output logic [C_W-1:0]         colourDisplay,
    output logic                   plotDisplay,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BC_W = $clog2(MAX_BURST) + 1;
    localparam logic [BC_W-1:0] BC_MAX  = BC_W'(MAX_BURST);
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(N_REQ - 1);
    localparam logic [ID_W:0]   N_CNT   = (ID_W + 1)'(N_REQ);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t            state_q;
    logic [N_REQ-1:0]  gnt_q;
    logic [ID_W-1:0]   gid_q;
    logic [ID_W-1:0]   last_id_q;
    logic [BC_W-1:0]   beat_q;
    logic [BC_W-1:0]   beat_d;
    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;
    logic [C_W-1:0]    c_q;
    logic              plot_q;
    logic              busy_q;
    logic              tmo_q;

    logic              pick_found_s;
    logic [ID_W-1:0]   pick_id_s;
    logic [ID_W-1:0]   cand_s;
    logic              g_valid_s;
    logic              g_last_s;
    logic              g_req_s;
    logic [X_W-1:0]    g_x_s;
    logic [Y_W-1:0]    g_y_s;
    logic [C_W-1:0]    g_c_s;
    logic              hit_max_s;
    logic              g_end_s;

    // Index of the requester k positions after base, wrapping modulo N_REQ.
    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
        logic [ID_W:0] sum;
        sum = {1'b0, base} + (ID_W + 1)'(k);
        sum = (sum >= N_CNT) ? (sum - N_CNT) : sum;
        return sum[ID_W-1:0];
    endfunction

    // Rotating-priority pick: scan from farthest to nearest so the nearest pending requester wins.
    always_comb begin
        pick_found_s = 1'b0;
        pick_id_s    = last_id_q;
        cand_s       = last_id_q;
        for (int k = N_REQ; k >= 1; k--) begin
            cand_s       = rr_idx(last_id_q, k);
            pick_found_s = pick_found_s | req[cand_s];
            pick_id_s    = req[cand_s] ? cand_s : pick_id_s;
        end
    end

    // Mux out the granted requester's request, beat qualifiers and pixel data.
    always_comb begin
        g_valid_s = 1'b0;
        g_last_s  = 1'b0;
        g_req_s   = 1'b0;
        g_x_s     = '0;
        g_y_s     = '0;
        g_c_s     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            g_valid_s = (gid_q == ID_W'(i)) ? pix_valid[i]              : g_valid_s;
            g_last_s  = (gid_q == ID_W'(i)) ? pix_last[i]               : g_last_s;
            g_req_s   = (gid_q == ID_W'(i)) ? req[i]                    : g_req_s;
            g_x_s     = (gid_q == ID_W'(i)) ? pix_x[i*X_W +: X_W]       : g_x_s;
            g_y_s     = (gid_q == ID_W'(i)) ? pix_y[i*Y_W +: Y_W]       : g_y_s;
            g_c_s     = (gid_q == ID_W'(i)) ? pix_colour[i*C_W +: C_W]  : g_c_s;
        end
    end

    // Saturating beat count and the three burst-termination conditions.
    always_comb begin
        beat_d    = (beat_q == BC_MAX) ? beat_q : (beat_q + BC_W'(1));
        hit_max_s = g_valid_s && (beat_d == BC_MAX);
        g_end_s   = (g_valid_s && (g_last_s || hit_max_s)) || !g_req_s;
    end

    // Arbitration FSM with all display/status outputs registered.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            gid_q     <= '0;
            last_id_q <= ID_LAST;
            beat_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            c_q       <= '0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    plot_q <= 1'b0;
                    tmo_q  <= 1'b0;
                    if (pick_found_s) begin
                        state_q   <= S_GRANT;
                        gnt_q     <= ONE_HOT0 << pick_id_s;
                        gid_q     <= pick_id_s;
                        last_id_q <= pick_id_s;
                        beat_q    <= '0;
                        busy_q    <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                S_GRANT: begin
                    plot_q <= g_valid_s;
                    // A limit hit coinciding with the natural last beat is not a forced release.
                    tmo_q  <= hit_max_s && !g_last_s;
                    if (g_valid_s) begin
                        x_q    <= g_x_s;
                        y_q    <= g_y_s;
                        c_q    <= g_c_s;
                        beat_q <= beat_d;
                    end else begin
                        beat_q <= beat_q;
                    end
                    if (g_end_s) begin
                        state_q <= S_RELEASE;
                        gnt_q   <= '0;
                    end else begin
                        state_q <= S_GRANT;
                    end
                    busy_q <= 1'b1;
                end
                S_RELEASE: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                    plot_q  <= 1'b0;
                    tmo_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                    plot_q  <= 1'b0;
                    tmo_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt           = gnt_q;
    assign xDisplay      = x_q;
    assign yDisplay      = y_q;
    assign colourDisplay = c_q;
    assign plotDisplay   = plot_q;
    assign busy          = busy_q;
    assign timeout_err   = tmo_q;

endmodule
